// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-select width and the pipeline sequencer state.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic {
    RUN,
    HALTED
  } pipectl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; cleared only by the async reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_control.sv
// Pipeline latch sequencer: enables/flushes for fetch..memory latches and the PC,
// halt tracking, and saturating stall/redirect performance counters.
module pipeline_control
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  regbits_t         ex_wsel,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             id_use_rt,
  input  logic             ex_redirect,
  output logic             pc_en,
  output logic             fl_en,
  output logic             fl_flush,
  output logic             dl_en,
  output logic             dl_flush,
  output logic             el_en,
  output logic             el_flush,
  output logic             ml_en,
  output logic             ml_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  pipectl_state_t state_reg, state_next;
  logic           halt_reg;
  logic           mem_stall;
  logic           load_use;
  logic [1:0]     inc_vec;          // [0] stall, [1] redirect
  logic [CNT_W-1:0] cnt_vec [2];

  assign mem_stall = mem_dreq && !dhit;
  assign load_use  = ex_dREN && (ex_wsel != '0) &&
                     ((ex_wsel == id_rs) || (id_use_rt && (ex_wsel == id_rt)));

  always_comb begin
    pc_en      = 1'b0;
    fl_en      = 1'b0;
    fl_flush   = 1'b0;
    dl_en      = 1'b0;
    dl_flush   = 1'b0;
    el_en      = 1'b0;
    el_flush   = 1'b0;
    ml_en      = 1'b0;
    ml_flush   = 1'b0;
    inc_vec    = 2'b00;
    state_next = state_reg;
    if (state_reg == RUN) begin
      if (mem_stall) begin
        inc_vec[0] = 1'b1;
      end else if (mem_halt) begin
        // Let the halt retire, squash everything younger.
        ml_en      = 1'b1;
        fl_flush   = 1'b1;
        dl_flush   = 1'b1;
        el_flush   = 1'b1;
        state_next = HALTED;
      end else if (ex_redirect) begin
        // Wins over load_use and ~ihit: the wrong-path work is flushed anyway.
        pc_en      = 1'b1;
        fl_flush   = 1'b1;
        dl_flush   = 1'b1;
        el_en      = 1'b1;
        ml_en      = 1'b1;
        inc_vec[1] = 1'b1;
      end else if (load_use || !ihit) begin
        dl_flush   = 1'b1;
        el_en      = 1'b1;
        ml_en      = 1'b1;
        inc_vec[0] = 1'b1;
      end else begin
        pc_en = 1'b1;
        fl_en = 1'b1;
        dl_en = 1'b1;
        el_en = 1'b1;
        ml_en = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= RUN;
      halt_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      halt_reg  <= (state_next == HALTED);
    end
  end

  assign halt = halt_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (inc_vec[gi]),
        .count (cnt_vec[gi])
      );
    end
  endgenerate

  assign stall_cnt = cnt_vec[0];
  assign redir_cnt = cnt_vec[1];

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: directed scenarios then random traffic.
module tb_pipeline_control;
  import cpu_types_pkg::*;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit = 1'b0, dhit = 1'b0, mem_dreq = 1'b0, mem_halt = 1'b0, ex_dREN = 1'b0;
  regbits_t ex_wsel = '0, id_rs = '0, id_rt = '0;
  logic id_use_rt = 1'b0, ex_redirect = 1'b0;
  logic pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush, halt;
  logic [CW-1:0] stall_cnt, redir_cnt;

  pipeline_control #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .mem_halt(mem_halt), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs),
    .id_rt(id_rt), .id_use_rt(id_use_rt), .ex_redirect(ex_redirect),
    .pc_en(pc_en), .fl_en(fl_en), .fl_flush(fl_flush), .dl_en(dl_en),
    .dl_flush(dl_flush), .el_en(el_en), .el_flush(el_flush), .ml_en(ml_en),
    .ml_flush(ml_flush), .halt(halt), .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic     ihit, dhit, mem_dreq, mem_halt, ex_dREN;
    regbits_t ex_wsel, id_rs, id_rt;
    logic     id_use_rt, ex_redirect;
  } stim_t;

  // outs order: {pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush}
  typedef struct packed {
    logic [8:0] outs;
    logic       halt;
    int         stall;
    int         redir;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit m_halted = 1'b0;
  int m_stall  = 0;
  int m_redir  = 0;

  // Which behaviour row applies this cycle; 0 means halted.
  function automatic int model_row(input stim_t s);
    bit stall_mem, lu;
    stall_mem = s.mem_dreq && !s.dhit;
    lu = s.ex_dREN && (s.ex_wsel != 0) &&
         ((s.ex_wsel == s.id_rs) || (s.id_use_rt && (s.ex_wsel == s.id_rt)));
    if (m_halted)         return 0;
    if (stall_mem)        return 1;
    if (s.mem_halt)       return 2;
    if (s.ex_redirect)    return 3;
    if (lu)               return 4;
    if (!s.ihit)          return 5;
    return 6;
  endfunction

  function automatic logic [8:0] row_outs(input int row);
    case (row)
      2:       return 9'b0_0_1_0_1_0_1_1_0;
      3:       return 9'b1_0_1_0_1_1_0_1_0;
      4, 5:    return 9'b0_0_0_0_1_1_0_1_0;
      6:       return 9'b1_1_0_1_0_1_0_1_0;
      default: return 9'b0;
    endcase
  endfunction

  task automatic step(input stim_t s, input bit rst);
    exp_t e;
    int   row;
    @(posedge CLK);
    #1;
    nRST = !rst;
    ihit = s.ihit; dhit = s.dhit; mem_dreq = s.mem_dreq; mem_halt = s.mem_halt;
    ex_dREN = s.ex_dREN; ex_wsel = s.ex_wsel; id_rs = s.id_rs; id_rt = s.id_rt;
    id_use_rt = s.id_use_rt; ex_redirect = s.ex_redirect;
    if (rst) begin
      m_halted = 1'b0;
      m_stall  = 0;
      m_redir  = 0;
    end
    row     = model_row(s);
    e.outs  = row_outs(row);
    e.halt  = m_halted;
    e.stall = m_stall;
    e.redir = m_redir;
    exp_q.push_back(e);
    if (!rst) begin
      if (row == 1 || row == 4 || row == 5) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (row == 3) m_redir = (m_redir < CMAX) ? m_redir + 1 : CMAX;
      if (row == 2) m_halted = 1'b1;
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = exp_q.pop_front();
      act = {pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush};
      n_cmp += 4;
      if (act !== e.outs) begin
        n_bad++;
        $display("FAIL outs t=%0t got=%b want=%b", $time, act, e.outs);
      end
      if (halt !== e.halt) begin
        n_bad++;
        $display("FAIL halt t=%0t got=%b want=%b", $time, halt, e.halt);
      end
      if (stall_cnt !== CW'(e.stall)) begin
        n_bad++;
        $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.stall);
      end
      if (redir_cnt !== CW'(e.redir)) begin
        n_bad++;
        $display("FAIL redir_cnt t=%0t got=%0d want=%0d", $time, redir_cnt, e.redir);
      end
    end
  end

  initial begin
    stim_t base, s;
    base = '0;
    base.ihit = 1'b1;

    // Reset, then clean run.
    step(base, 1'b1);
    step(base, 1'b1);
    repeat (3) step(base, 1'b0);

    // Memory stall for 3 cycles, then dhit.
    s = base; s.mem_dreq = 1'b1;
    repeat (3) step(s, 1'b0);
    s.dhit = 1'b1;
    step(s, 1'b0);
    step(base, 1'b0);

    // Load-use on rs, then x0 destination (no hazard).
    s = base; s.ex_dREN = 1'b1; s.ex_wsel = 5'd5; s.id_rs = 5'd5;
    step(s, 1'b0);
    s.ex_wsel = 5'd0; s.id_rs = 5'd0;
    step(s, 1'b0);
    // Load-use via rt.
    s = base; s.ex_dREN = 1'b1; s.ex_wsel = 5'd7; s.id_rt = 5'd7; s.id_use_rt = 1'b1;
    step(s, 1'b0);

    // Redirect beats load_use and ~ihit.
    s = base; s.ihit = 1'b0; s.ex_dREN = 1'b1; s.ex_wsel = 5'd3; s.id_rs = 5'd3;
    s.ex_redirect = 1'b1;
    step(s, 1'b0);
    step(base, 1'b0);

    // Halt behind a memory stall, then ignored redirect.
    s = base; s.mem_halt = 1'b1; s.mem_dreq = 1'b1;
    repeat (2) step(s, 1'b0);
    s.dhit = 1'b1;
    step(s, 1'b0);
    step(base, 1'b0);
    s = base; s.ex_redirect = 1'b1;
    repeat (2) step(s, 1'b0);

    // Reset out of HALTED, then saturate stall_cnt, reset mid-stall.
    step(base, 1'b1);
    s = base; s.ihit = 1'b0;
    repeat (CMAX + 4) step(s, 1'b0);
    step(s, 1'b1);
    repeat (2) step(s, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s.ihit        = ($urandom_range(0, 99) < 80);
      s.dhit        = ($urandom_range(0, 99) < 60);
      s.mem_dreq    = ($urandom_range(0, 99) < 30);
      s.mem_halt    = ($urandom_range(0, 99) < 3);
      s.ex_dREN     = ($urandom_range(0, 99) < 35);
      s.ex_wsel     = 5'($urandom_range(0, 3));
      s.id_rs       = 5'($urandom_range(0, 3));
      s.id_rt       = 5'($urandom_range(0, 3));
      s.id_use_rt   = 1'($urandom_range(0, 1));
      s.ex_redirect = ($urandom_range(0, 99) < 15);
      step(s, ($urandom_range(0, 99) < 3));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
